// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults for the programmable serial sequence detector.
package seq_det_pkg;
   localparam int MAX_LEN_DEF = 8;
   localparam int LEN_W = $clog2(MAX_LEN_DEF + 1);
   localparam logic [MAX_LEN_DEF-1:0] RST_PATTERN_DEF = 8'b0001_1011;
   localparam int RST_LEN_DEF = 5;
   localparam logic RST_OVERLAP_DEF = 1'b0;
endpackage

// File: rtl/seq_det_history.sv
// seq_det_history: received-bit history (newest at [0]) plus a saturating count
// of how many valid bits are held since the last clear.
module seq_det_history
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       shift,
   input  logic                       in_bit,
   input  logic                       clr_fill,
   output logic [MAX_LEN-2:0]         hist,
   output logic [$clog2(MAX_LEN)-1:0] fill
);
   localparam int FW = $clog2(MAX_LEN);
   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
      end else begin
         if (shift) hist <= (MAX_LEN-1)'({hist, in_bit});
         if (clr_fill) fill <= '0;
         else if (shift) fill <= (fill == FW'(MAX_LEN - 1)) ? fill : fill + FW'(1);
      end
   end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with Mealy match,
// registered match, saturating match counter and config-error pulse.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int CNT_W = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(RST_PATTERN_DEF),
   parameter int RST_LEN = RST_LEN_DEF,
   parameter logic RST_OVERLAP = RST_OVERLAP_DEF
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_bit,
   input  logic                         cfg_load,
   input  logic [MAX_LEN-1:0]           cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         clear_count,
   output logic                         match,
   output logic                         match_q,
   output logic [CNT_W-1:0]             match_count,
   output logic                         cfg_err
);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int FW = $clog2(MAX_LEN);
   logic [MAX_LEN-1:0] pat;
   logic [LW-1:0] len;
   logic ovl;
   logic [MAX_LEN-2:0] hist;
   logic [FW-1:0] fill;
   logic [MAX_LEN-1:0] mask;
   logic legal, shift, hit, clr_fill;
   // Only the low len bits of {hist, in_bit} take part; fill guards against stale history.
   always_comb begin
      legal = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
      mask = ~({MAX_LEN{1'b1}} << len);
      hit = ((({hist, in_bit} ^ pat) & mask) == '0) && ((LW'(fill) + LW'(1)) >= len);
      shift = in_valid & ~cfg_load;
      match = shift & ~rst & hit;
      clr_fill = (cfg_load & legal) | (match & ~ovl);
   end
   seq_det_history #(.MAX_LEN(MAX_LEN)) u_hist (
      .clk(clk),
      .rst(rst),
      .shift(shift),
      .in_bit(in_bit),
      .clr_fill(clr_fill),
      .hist(hist),
      .fill(fill)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         pat <= RST_PATTERN;
         len <= LW'(RST_LEN);
         ovl <= RST_OVERLAP;
         match_q <= 1'b0;
         match_count <= '0;
         cfg_err <= 1'b0;
      end else begin
         if (cfg_load && legal) begin
            pat <= cfg_pattern;
            len <= cfg_len;
            ovl <= cfg_overlap;
         end
         match_q <= match;
         match_count <= clear_count ? '0 : (match && ~&match_count) ? match_count + CNT_W'(1) : match_count;
         cfg_err <= cfg_load & ~legal;
      end
   end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed stimulus with hand-computed match expectations,
// checked through a scoreboard queue by a free-running monitor.
module tb_seq_detector_param;
   logic clk = 0, rst = 1, in_valid = 0, in_bit = 0, cfg_load = 0, cfg_overlap = 0, clear_count = 0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic match, match_q, cfg_err;
   logic [1:0] match_count;
   typedef struct {string name; logic m; logic mq; logic [1:0] cnt; logic err;} exp_t;
   exp_t q[$];
   int compared = 0, mismatched = 0;
   string tag = "reset";
   logic mq_e = 0, err_e = 0;
   logic [1:0] cnt_e = 0;

   seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .clear_count(clear_count), .match(match), .match_q(match_q),
      .match_count(match_count), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         compared++;
         if ({match, match_q, match_count, cfg_err} !== {e.m, e.mq, e.cnt, e.err}) begin
            mismatched++;
            $display("FAIL %s: got match=%b match_q=%b count=%0d cfg_err=%b, expected %b %b %0d %b",
                     e.name, match, match_q, match_count, cfg_err, e.m, e.mq, e.cnt, e.err);
         end
      end
   end

   task automatic step(input logic v, b, ld, input logic [7:0] p, input logic [3:0] l,
                       input logic o, clr, r, em);
      @(posedge clk);
      #1;
      in_valid = v; in_bit = b; cfg_load = ld; clear_count = clr; rst = r;
      if (ld) begin cfg_pattern = p; cfg_len = l; cfg_overlap = o; end
      q.push_back('{tag, em, mq_e, cnt_e, err_e});
      mq_e = r ? 1'b0 : em;
      cnt_e = (r || clr) ? 2'd0 : (em && cnt_e != 2'd3) ? cnt_e + 2'd1 : cnt_e;
      err_e = !r && ld && (l == 0 || l > 8);
   endtask

   task automatic bits(input logic [15:0] b, input logic [15:0] em, input int n);
      for (int i = n - 1; i >= 0; i--) step(1, b[i], 0, 0, 0, 0, 0, 0, em[i]);
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
      step(0, 0, 1, p, l, o, 0, 0, 0);
   endtask

   task automatic idle(input logic clr);
      step(0, 0, 0, 0, 0, 0, clr, 0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      tag = "default_nonovl";
      bits(16'b1101_1011, 16'b0000_1000, 8);
      idle(1);
      tag = "overlap";
      load(8'b1_1011, 4'd5, 1);
      bits(16'b1101_1011, 16'b0000_1001, 8);
      idle(1);
      tag = "len1";
      load(8'h01, 4'd1, 0);
      bits(16'b101, 16'b101, 3);
      idle(1);
      tag = "len8";
      load(8'hA5, 4'd8, 0);
      bits(16'hA5A5, 16'h0101, 16);
      idle(1);
      tag = "illegal_cfg";
      load(8'b1_1011, 4'd5, 0);
      bits(16'b11, 16'b00, 2);
      load(8'hFF, 4'd0, 1);
      bits(16'b0, 16'b0, 1);
      load(8'hFF, 4'd9, 1);
      bits(16'b11, 16'b01, 2);
      idle(0);
      tag = "load_collide";
      bits(16'b1101, 16'b0000, 4);
      step(1, 1, 1, 8'b1_1011, 4'd5, 0, 0, 0, 0);
      bits(16'b1, 16'b0, 1);
      idle(0);
      tag = "reset_mid";
      bits(16'b1101, 16'b0000, 4);
      step(1, 1, 0, 0, 0, 0, 0, 1, 0);
      bits(16'b1, 16'b0, 1);
      bits(16'b11011, 16'b00001, 5);
      idle(0);
      tag = "saturate";
      load(8'h01, 4'd1, 1);
      bits(16'b11111, 16'b11111, 5);
      idle(0);
      tag = "clear_vs_match";
      step(1, 1, 0, 0, 0, 0, 1, 0, 1);
      idle(0);
      idle(0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
